ber_ctrl: RTL and testbench
===========================

# ber_ctrl

Measurement controller for the bit-error-ratio tester. It sequences one BER measurement:
- locks the local reference pattern generator to the received byte stream;
- compares a programmed window of received bytes against the reference;
- accumulates bit and bit-error totals, then holds the result for software.

It sits between the byte-wide receive path, the pattern generator and the byte comparator/error datapath, and replaces the free-running, unclocked counting of that datapath with a clocked, windowed sequence.

## Interface
Parameters:
- CNT_W, 32, width of bit/error counters and of the window register
- SYNC_LEN, 4, consecutive error-free bytes required to declare lock
- LOSS_LEN, 8, consecutive bad bytes that drop lock (BER_RESYNC_EN only)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin measurement; accepted only in IDLE or DONE with window != 0
- abort  in  1  cancel measurement, return to IDLE
- window  in  CNT_W  number of bytes to measure in RUN; sampled when start is accepted
- rx_valid  in  1  rx_byte valid this cycle
- rx_byte  in  8  received byte
- ref_byte  in  8  current reference byte from pattern generator
- ref_adv  out  1  generator steps to next byte (combinational)
- ref_load  out  1  generator reseeds from rx_byte (combinational)
- busy  out  1  state is SYNC or RUN
- lock  out  1  state is RUN
- done  out  1  state is DONE
- bit_count  out  CNT_W  bits compared in RUN
- err_count  out  CNT_W  bit errors in RUN, saturating
- err_sat  out  1  err_count saturated (sticky)

## Operation
- States: IDLE, SYNC, RUN, DONE.
- IDLE:
  - start with window != 0 → SYNC.
  - Clear bit_count, err_count, err_sat, sync and byte counters; latch window.
  - ref_load=1 that cycle.
  - start with window == 0 is ignored.
- SYNC, per valid byte:
  - rx_byte == ref_byte: sync counter +1, ref_adv=1.
  - Mismatch: sync counter cleared, ref_load=1, ref_adv=0.
  - When sync counter reaches SYNC_LEN → RUN.
  - SYNC bytes are never counted.
- RUN, per valid byte:
  - ref_adv=1.
  - bit_count += 8; err_count += popcount(rx_byte ^ ref_byte), range 0..8.
  - Byte counter +1; when it equals the latched window → DONE.
- DONE:
  - done=1; counters hold indefinitely.
  - start behaves as in IDLE (restart, counters cleared).
- abort in SYNC/RUN/DONE → IDLE. Counters hold their values; done, busy and lock drop.
- Priority: rst_n > abort > start > rx_valid. start while busy is ignored.
- Arithmetic:
  - err_count saturates at 2^CNT_W−1 and sets err_sat; err_sat stays set until the next accepted start.
  - bit_count needs no saturation: RUN is bounded by window, but the addition wraps modulo 2^CNT_W if window > (2^CNT_W−1)/8.
- ref_adv and ref_load are never both 1. Both are 0 when rx_valid=0 or in IDLE/DONE, except ref_load on an accepted start.

## Timing
- Reset values: state IDLE; all outputs 0; internal counters 0.
- Counters and state are registered. The effect of a valid byte at cycle N is visible at cycle N+1.
- done rises in the same cycle the final counter values appear, i.e. one cycle after the last window byte.
- lock rises one cycle after the SYNC_LEN-th matching byte.
- ref_adv and ref_load are combinational from rx_valid, state and the compare result. The generator must present the new ref_byte by the next cycle.
- Back-to-back rx_valid is supported at full rate, one byte per cycle. Gaps are allowed anywhere.
- Reset mid-measurement returns to IDLE in one cycle with all counts zero.

## Configuration
- BER_RESYNC_EN defined:
  - In RUN, a byte with popcount ≥ 4 is "bad".
  - LOSS_LEN consecutive bad bytes → SYNC, with lock=0. The sync counter clears; RUN counters and the byte counter hold and resume after relock.
  - Bytes seen in SYNC are not counted.
- Not defined: RUN never leaves except by window completion, abort or reset; no loss counter is present.

## Structure
- Shared package ber_pkg:
  - state enum (IDLE/SYNC/RUN/DONE);
  - CNT_W default;
  - bad-byte threshold constant (4).
- One sub-module: ber_popcount8, purely combinational, 8-bit XOR-diff → 4-bit error count.

## Test plan
- Clean lock:
  - Setup: window=16, SYNC_LEN=4, rx_byte always equals ref_byte.
  - Required: lock rises 1 cycle after 4th valid byte; done after 16 RUN bytes; bit_count=128, err_count=0.
- Known errors:
  - Setup: window=4, RUN bytes with XOR diffs 0x01, 0xFF, 0x00, 0x0F.
  - Required: err_count=13, bit_count=32.
- Sync retry:
  - Setup: SYNC stream match, match, mismatch, then 4 matches.
  - Required: ref_load pulses exactly on the mismatch cycle; lock only after the final 4 matches.
- Abort and restart:
  - Setup: abort mid-RUN after 5 bytes, then start again.
  - Required: IDLE next cycle with bit_count=40 held; restart clears it to 0.
- Saturation and reset:
  - Setup: CNT_W=4, all-0xFF diffs.
  - Required: err_count sticks at 15 and err_sat=1.
  - Then: rst_n low mid-RUN; next cycle all outputs 0, state IDLE.
- BER_RESYNC_EN:
  - Setup: 8 consecutive 0xF0-diff bytes in RUN.
  - Required: lock drops; after relock, bit_count continues from its held value.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared types and constants for the BER measurement controller.
package ber_pkg;

    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned BAD_THRESH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ber_popcount8.sv
// Counts the set bits of an 8-bit compare difference (0..8).
module ber_popcount8 (
    input  logic [7:0] diff,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(diff[i]);
        end
    end

endmodule

// File: rtl/ber_ctrl.sv
// BER measurement sequencer: lock the reference generator, count a window of bytes, hold result.
// Optional BER_RESYNC_EN: a run of bad bytes in RUN drops lock and returns to SYNC.
module ber_ctrl
    import ber_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned SYNC_LEN = 4,
    parameter int unsigned LOSS_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] window,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic [7:0]       ref_byte,
    output logic             ref_adv,
    output logic             ref_load,
    output logic             busy,
    output logic             lock,
    output logic             done,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sat
);

    // Sync and loss counters share one width, sized for the longer run length.
    localparam int unsigned CTR_W =
        $clog2(((SYNC_LEN > LOSS_LEN) ? SYNC_LEN : LOSS_LEN) + 1);
    localparam logic [CTR_W-1:0] SYNC_LAST = CTR_W'(SYNC_LEN);

    state_t           state;
    logic [CNT_W-1:0] window_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] byte_next;
    logic [CTR_W-1:0] sync_cnt;
    logic [CTR_W-1:0] sync_next;
    logic [3:0]       diff_pop;
    logic [CNT_W:0]   err_sum;
    logic             match;
    logic             start_ok;
    logic             byte_ok;

    ber_popcount8 u_pop (
        .diff  (rx_byte ^ ref_byte),
        .count (diff_pop)
    );

    // abort outranks start, and both outrank a received byte.
    assign match     = (rx_byte == ref_byte);
    assign byte_ok   = rx_valid && !abort;
    assign start_ok  = start && !abort && (window != '0) && ((state == IDLE) || (state == DONE));
    assign ref_adv   = byte_ok && ((state == RUN) || ((state == SYNC) && match));
    assign ref_load  = start_ok || (byte_ok && (state == SYNC) && !match);
    assign err_sum   = {1'b0, err_count} + (CNT_W + 1)'(diff_pop);
    assign byte_next = byte_cnt + CNT_W'(1);
    assign sync_next = sync_cnt + CTR_W'(1);

    assign busy = (state == SYNC) || (state == RUN);
    assign lock = (state == RUN);
    assign done = (state == DONE);

`ifdef BER_RESYNC_EN
    localparam logic [CTR_W-1:0] LOSS_LAST = CTR_W'(LOSS_LEN);
    logic [CTR_W-1:0] loss_cnt;
    logic             bad;
    assign bad = (diff_pop >= 4'(BAD_THRESH));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            window_q  <= '0;
            byte_cnt  <= '0;
            sync_cnt  <= '0;
            bit_count <= '0;
            err_count <= '0;
            err_sat   <= 1'b0;
`ifdef BER_RESYNC_EN
            loss_cnt  <= '0;
`endif
        end else if (abort && (state != IDLE)) begin
            state <= IDLE;
        end else if (start_ok) begin
            state     <= SYNC;
            window_q  <= window;
            byte_cnt  <= '0;
            sync_cnt  <= '0;
            bit_count <= '0;
            err_count <= '0;
            err_sat   <= 1'b0;
`ifdef BER_RESYNC_EN
            loss_cnt  <= '0;
`endif
        end else if (byte_ok) begin
            case (state)
                SYNC: begin
                    if (match) begin
                        sync_cnt <= sync_next;
                        if (sync_next == SYNC_LAST) begin
                            state <= RUN;
                        end
                    end else begin
                        sync_cnt <= '0;
                    end
`ifdef BER_RESYNC_EN
                    loss_cnt <= '0;
`endif
                end
                RUN: begin
                    bit_count <= bit_count + CNT_W'(8);
                    if (err_sum[CNT_W]) begin
                        err_count <= '1;
                        err_sat   <= 1'b1;
                    end else begin
                        err_count <= err_sum[CNT_W-1:0];
                    end
                    byte_cnt <= byte_next;
`ifdef BER_RESYNC_EN
                    if (byte_next == window_q) begin
                        state <= DONE;
                    end else if (bad && ((loss_cnt + CTR_W'(1)) == LOSS_LAST)) begin
                        state    <= SYNC;
                        sync_cnt <= '0;
                        loss_cnt <= '0;
                    end else if (bad) begin
                        loss_cnt <= loss_cnt + CTR_W'(1);
                    end else begin
                        loss_cnt <= '0;
                    end
`else
                    if (byte_next == window_q) begin
                        state <= DONE;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ber_ctrl.sv
// Directed self-checking bench for ber_ctrl (32-bit instance plus a 4-bit instance for saturation).
module tb_ber_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] window;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  ref_byte;

    logic        ref_adv, ref_load, busy, lock, done, err_sat;
    logic [31:0] bit_count, err_count;
    logic        ref_adv4, ref_load4, busy4, lock4, done4, err_sat4;
    logic [3:0]  bit_count4, err_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ber_ctrl #(.CNT_W(32), .SYNC_LEN(4), .LOSS_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window(window),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .ref_byte(ref_byte),
        .ref_adv(ref_adv), .ref_load(ref_load), .busy(busy), .lock(lock), .done(done),
        .bit_count(bit_count), .err_count(err_count), .err_sat(err_sat)
    );

    ber_ctrl #(.CNT_W(4), .SYNC_LEN(4), .LOSS_LEN(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window(window[3:0]),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .ref_byte(ref_byte),
        .ref_adv(ref_adv4), .ref_load(ref_load4), .busy(busy4), .lock(lock4), .done(done4),
        .bit_count(bit_count4), .err_count(err_count4), .err_sat(err_sat4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rx_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
    endtask

    // One valid byte: reference value plus the XOR difference applied to the received byte.
    task automatic send(input logic [7:0] rb, input logic [7:0] diff);
        rx_valid = 1'b1;
        ref_byte = rb;
        rx_byte  = rb ^ diff;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] w);
        window = w;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic sync4();
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; window = '0; ref_byte = '0; rx_byte = '0;
        idle_in();
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bits", bit_count, 32'd0);
        chk("rst_errs", err_count, 32'd0);
        chk("rst_sat", 32'(err_sat), 32'd0);
        chk("rst_strobes", {30'd0, ref_adv, ref_load}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Clean lock, window 16
        window = 32'd16; start = 1'b1; #1;
        chk("start_load", {30'd0, ref_adv, ref_load}, 32'b01);
        tick(); start = 1'b0;
        chk("sync_busy", {30'd0, busy, lock}, 32'b10);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; ref_byte = 8'h10 + 8'(i); rx_byte = ref_byte; #1;
            if (i == 0) chk("sync_adv", {30'd0, ref_adv, ref_load}, 32'b10);
            tick();
            if (i == 2) chk("lock_early", 32'(lock), 32'd0);
        end
        rx_valid = 1'b0;
        chk("lock_rise", 32'(lock), 32'd1);
        chk("sync_uncounted", bit_count, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                #1;
                chk("gap_no_adv", 32'(ref_adv), 32'd0);
                tick();
            end
            send(8'h50 + 8'(i), 8'h00);
            if (i == 14) begin
                chk("pre_done", 32'(done), 32'd0);
                chk("pre_bits", bit_count, 32'd120);
            end
        end
        chk("clean_done", {29'd0, busy, lock, done}, 32'b001);
        chk("clean_bits", bit_count, 32'd128);
        chk("clean_errs", err_count, 32'd0);
        rx_valid = 1'b1; rx_byte = 8'h00; ref_byte = 8'h01; #1;
        chk("done_strobes", {30'd0, ref_adv, ref_load}, 32'd0);
        tick(); rx_valid = 1'b0;
        chk("done_hold", bit_count, 32'd128);

        // Known errors, window 4
        do_start(32'd4);
        chk("restart_clear", bit_count, 32'd0);
        sync4();
        send(8'hA5, 8'h01);
        send(8'hA6, 8'hFF);
        send(8'hA7, 8'h00);
        send(8'hA8, 8'h0F);
        chk("known_errs", err_count, 32'd13);
        chk("known_bits", bit_count, 32'd32);
        chk("known_done", 32'(done), 32'd1);
        do_start(32'd0);
        chk("zero_win_ignored", {31'd0, done}, 32'd1);
        chk("zero_win_hold", bit_count, 32'd32);

        // Sync retry: match, match, mismatch, then four matches
        do_start(32'd4);
        for (int i = 0; i < 7; i++) begin
            rx_valid = 1'b1;
            ref_byte = 8'h70 + 8'(i);
            rx_byte  = (i == 2) ? 8'h00 : ref_byte;
            #1;
            chk($sformatf("retry_strobe%0d", i), {30'd0, ref_adv, ref_load},
                (i == 2) ? 32'b01 : 32'b10);
            tick();
            if (i == 5) chk("retry_no_lock", 32'(lock), 32'd0);
        end
        rx_valid = 1'b0;
        chk("retry_lock", 32'(lock), 32'd1);

        // Abort mid-RUN after five bytes; a start while busy is ignored
        abort = 1'b1; tick(); abort = 1'b0;
        do_start(32'd16);
        sync4();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; window = 32'd1; end
            send(8'h90 + 8'(i), 8'h00);
            start = 1'b0;
        end
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_flags", {29'd0, busy, lock, done}, 32'd0);
        chk("abort_bits", bit_count, 32'd40);
        do_start(32'd16);
        chk("abort_restart_bits", bit_count, 32'd0);
        chk("abort_restart_busy", 32'(busy), 32'd1);

        // Saturation on the 4-bit instance, then reset mid-RUN
        abort = 1'b1; tick(); abort = 1'b0;
        do_start(32'd15);
        sync4();
        send(8'h11, 8'hFF);
        chk("sat4_errs1", 32'(err_count4), 32'd8);
        chk("sat4_flag1", 32'(err_sat4), 32'd0);
        send(8'h12, 8'hFF);
        chk("sat4_errs2", 32'(err_count4), 32'd15);
        chk("sat4_flag2", 32'(err_sat4), 32'd1);
        chk("sat4_bits_wrap", 32'(bit_count4), 32'd0);
        send(8'h13, 8'hFF);
        chk("sat4_errs3", 32'(err_count4), 32'd15);
        chk("sat4_flag3", 32'(err_sat4), 32'd1);
        chk("wide_errs", err_count, 32'd24);
        rst_n = 1'b0; tick();
        chk("mrst_flags", {26'd0, busy, lock, done, busy4, lock4, done4}, 32'd0);
        chk("mrst_bits", bit_count, 32'd0);
        chk("mrst_errs", err_count, 32'd0);
        chk("mrst4", {22'd0, bit_count4, err_count4, err_sat4, err_sat}, 32'd0);
        rst_n = 1'b1; tick();

        // Eight bad bytes in RUN
        do_start(32'd32);
        sync4();
        send(8'hC0, 8'h00);
        send(8'hC1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            send(8'hD0 + 8'(i), 8'hF0);
            if (i == 6) chk("loss_pre", 32'(lock), 32'd1);
        end
        chk("loss_bits", bit_count, 32'd80);
        chk("loss_errs", err_count, 32'd32);
`ifdef BER_RESYNC_EN
        chk("loss_drop", {30'd0, busy, lock}, 32'b10);
        sync4();
        chk("relock", 32'(lock), 32'd1);
        chk("relock_bits_held", bit_count, 32'd80);
`else
        chk("no_loss_lock", {30'd0, busy, lock}, 32'b11);
`endif
        send(8'hE0, 8'h00);
        chk("resume_bits", bit_count, 32'd88);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
